// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder and normalize/pack stages.
// Widths, packed-word field offsets and the normalizer state encoding live
// here so every stage agrees on the single-precision layout.
package fp_pkg;

    // Field widths of the internal operand representation
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 24;          // includes the hidden bit
    localparam int FRAC_W = MAN_W - 1;   // stored fraction bits
    localparam int WORD_W = 32;

    // All-ones exponent: infinity / NaN encoding
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Bit positions inside the packed IEEE-754 single-precision word
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    // Normalizer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : fp_pkg

// File: rtl/fp_pack.sv
// Combinational packer: assembles {sign, exponent, fraction} into a
// single-precision word. Zero forcing wins over infinity forcing; infinity
// forcing keeps the sign and replaces exponent/fraction with EXP_MAX / 0.
module fp_pack
    import fp_pkg::*;
(
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              force_inf_i,
    input  logic              force_zero_i,
    output logic [WORD_W-1:0] word_o
);

    // Field assembly followed by special-value overrides
    always_comb begin
        word_o                   = '0;
        word_o[SIGN_BIT]         = sign_i;
        word_o[EXP_MSB:EXP_LSB]  = exp_i;
        word_o[EXP_LSB-1:0]      = frac_i;

        if (force_zero_i) begin
            // Exact cancellation or flush: always +0
            word_o = '0;
        end else if (force_inf_i) begin
            word_o[EXP_MSB:EXP_LSB] = EXP_MAX;
            word_o[EXP_LSB-1:0]     = '0;
        end
    end

endmodule : fp_pack

// File: rtl/fp_normalize_pack.sv
// Normalization and packing stage behind the mantissa adder. Accepts the raw
// sign/exponent/mantissa/carry, applies the carry pre-shift at accept, then
// left-shifts one bit per cycle until the mantissa is normalized or a special
// case (overflow, NaN/Inf passthrough, zero, underflow) resolves it. The
// packed word and flags are registered and held until the downstream
// handshake completes. Truncating rounding; denormals flush to zero.
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              S_In,
    input  logic [EXP_W-1:0]  E_In,
    input  logic [MAN_W-1:0]  M_In,
    input  logic              Carry_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [WORD_W-1:0] Result,
    output logic              Overflow,
    output logic              Underflow,
    output logic              Zero
);

    // Control and working operand registers
    state_t             state_q, state_d;
    logic               s_q, s_d;
    logic [EXP_W-1:0]   e_q, e_d;
    logic [MAN_W-1:0]   m_q, m_d;
    logic               ovf_q, ovf_d;       // set by a carry into EXP_MAX

    // Registered output word and flags
    logic [WORD_W-1:0]  result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               zero_q, zero_d;

    // Decode of the NORM-state rules, evaluated in priority order
    logic               exp_special;        // rule 1: overflow or Inf/NaN
    logic               man_zero;           // rule 2: exact cancellation
    logic               man_norm;           // rule 3: hidden bit in place
    logic               exp_low;            // rule 4: no room to shift
    logic               norm_done;
    logic               force_zero;
    logic [EXP_W-1:0]   e_inc;
    logic [WORD_W-1:0]  pack_word;

    assign exp_special = ovf_q || (e_q == EXP_MAX);
    assign man_zero    = (m_q == '0);
    assign man_norm    = m_q[MAN_W-1];
    assign exp_low     = (e_q <= EXP_W'(1));
    assign norm_done   = exp_special || man_zero || man_norm || exp_low;
    // Zero result for cancellation or underflow, unless a special exponent wins
    assign force_zero  = !exp_special && (man_zero || (!man_norm && exp_low));

    // Exponent after the carry pre-shift
    assign e_inc = E_In + EXP_W'(1);

    fp_pack u_pack (
        .sign_i       (s_q),
        .exp_i        (e_q),
        .frac_i       (m_q[FRAC_W-1:0]),
        .force_inf_i  (ovf_q),
        .force_zero_i (force_zero),
        .word_o       (pack_word)
    );

    // Next-state logic: accept, one normalization step per cycle, handshake
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        m_d         = m_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    s_d     = S_In;
                    ovf_d   = 1'b0;
                    state_d = NORM;
                    if (Carry_In && (E_In != EXP_MAX)) begin
                        // Carry-out becomes the new hidden bit; LSB is dropped
                        m_d   = {1'b1, M_In[MAN_W-1:1]};
                        e_d   = e_inc;
                        ovf_d = (e_inc == EXP_MAX);
                    end else begin
                        m_d = M_In;
                        e_d = E_In;
                    end
                end
            end

            NORM: begin
                if (norm_done) begin
                    state_d     = DONE;
                    result_d    = pack_word;
                    overflow_d  = ovf_q;
                    underflow_d = force_zero && !man_zero;
                    zero_d      = force_zero;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - EXP_W'(1);
                end
            end

            DONE: begin
                if (Out_Ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (Reset) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            m_q         <= m_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            zero_q      <= zero_d;
        end
    end

    assign In_Ready  = (state_q == IDLE);
    assign Out_Valid = (state_q == DONE);
    assign Result    = result_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
    assign Zero      = zero_q;

endmodule : fp_normalize_pack

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: a table of operand vectors with
// hand-derived packed results, flags and latencies, a scoreboard queue filled
// at accept and drained when Out_Valid appears, plus reset sequences.
module tb_fp_normalize_pack;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic        S_In;
    logic [7:0]  E_In;
    logic [23:0] M_In;
    logic        Carry_In;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Result;
    logic        Overflow;
    logic        Underflow;
    logic        Zero;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        c;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    fp_normalize_pack dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .S_In      (S_In),
        .E_In      (E_In),
        .M_In      (M_In),
        .Carry_In  (Carry_In),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Result    (Result),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Zero      (Zero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic s, input logic [7:0] e,
                                input logic [23:0] m, input logic c, input logic [31:0] r,
                                input logic ovf, input logic unf, input logic z,
                                input int lat, input int hold);
        vec_t v;
        v.name = n; v.s = s; v.e = e; v.m = m; v.c = c; v.res = r;
        v.ovf = ovf; v.unf = unf; v.zero = z; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    task automatic scramble_inputs();
        S_In     = 1'($urandom);
        E_In     = 8'($urandom);
        M_In     = 24'($urandom);
        Carry_In = 1'($urandom);
    endtask

    // Called at posedge+1 with the DUT in IDLE
    task automatic run_vec(input vec_t v);
        vec_t exp_v;
        int   lat;
        check({v.name, "/in_ready_idle"}, 32'(In_Ready), 32'd1);
        S_In = v.s; E_In = v.e; M_In = v.m; Carry_In = v.c; In_Valid = 1'b1;
        exp_q.push_back(v);
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        scramble_inputs();
        check({v.name, "/in_ready_busy"}, 32'(In_Ready), 32'd0);
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
        end while (!Out_Valid && lat < 40);
        if (!Out_Valid) begin
            check({v.name, "/timeout"}, 32'(Out_Valid), 32'd1);
            exp_q.delete();
            Reset = 1'b1;
            @(posedge Clk); #1;
            Reset = 1'b0;
            return;
        end
        exp_v = exp_q.pop_front();
        check({exp_v.name, "/latency"},   32'(lat),       32'(exp_v.lat));
        check({exp_v.name, "/result"},    Result,         exp_v.res);
        check({exp_v.name, "/overflow"},  32'(Overflow),  32'(exp_v.ovf));
        check({exp_v.name, "/underflow"}, 32'(Underflow), 32'(exp_v.unf));
        check({exp_v.name, "/zero"},      32'(Zero),      32'(exp_v.zero));
        // Backpressure: ignored input traffic, output must stay put
        for (int h = 0; h < exp_v.hold; h++) begin
            In_Valid = 1'b1;
            scramble_inputs();
            @(posedge Clk); #1;
            check({exp_v.name, "/hold_valid"},  32'(Out_Valid), 32'd1);
            check({exp_v.name, "/hold_result"}, Result,         exp_v.res);
            check({exp_v.name, "/hold_flags"},  {29'd0, Overflow, Underflow, Zero},
                  {29'd0, exp_v.ovf, exp_v.unf, exp_v.zero});
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        check({exp_v.name, "/valid_drop"}, 32'(Out_Valid), 32'd0);
        check({exp_v.name, "/back_idle"},  32'(In_Ready),  32'd1);
    endtask

    initial begin
        int seen_valid;

        Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
        S_In = 1'b0; E_In = '0; M_In = '0; Carry_In = 1'b0;

        //          name          s    e      m          c    result         ovf  unf  z  lat hold
        vecs.push_back(mk("add_1p5",   0, 8'h7F, 24'h800000, 1, 32'h40400000, 0, 0, 0, 1,  0));
        vecs.push_back(mk("backpress", 1, 8'h80, 24'hA00000, 0, 32'hC0200000, 0, 0, 0, 1,  5));
        vecs.push_back(mk("deep_canc", 0, 8'h7F, 24'h000001, 0, 32'h34000000, 0, 0, 0, 24, 0));
        vecs.push_back(mk("exact_zero",1, 8'h85, 24'h000000, 0, 32'h00000000, 0, 0, 1, 1,  0));
        vecs.push_back(mk("overflow",  0, 8'hFE, 24'hC00000, 1, 32'h7F800000, 1, 0, 0, 1,  0));
        vecs.push_back(mk("underflow", 1, 8'h02, 24'h100000, 0, 32'h00000000, 0, 1, 1, 2,  0));
        vecs.push_back(mk("nan_pass",  0, 8'hFF, 24'hC00001, 0, 32'h7FC00001, 0, 0, 0, 1,  0));
        vecs.push_back(mk("inf_carry", 1, 8'hFF, 24'h800000, 1, 32'hFF800000, 0, 0, 0, 1,  0));
        vecs.push_back(mk("carry_trunc",0,8'h10, 24'hFFFFFF, 1, 32'h08FFFFFF, 0, 0, 0, 1,  0));
        vecs.push_back(mk("unf_e1",    0, 8'h01, 24'h400000, 0, 32'h00000000, 0, 1, 1, 1,  0));
        vecs.push_back(mk("norm_e0",   0, 8'h00, 24'h800000, 0, 32'h00000000, 0, 0, 0, 1,  0));
        vecs.push_back(mk("unf_shift", 1, 8'h03, 24'h000010, 0, 32'h00000000, 0, 1, 1, 3,  0));
        vecs.push_back(mk("two_shift", 0, 8'h81, 24'h200000, 0, 32'h3F800000, 0, 0, 0, 3,  2));

        repeat (2) @(posedge Clk);
        #1;
        check("reset/in_ready",  32'(In_Ready),  32'd1);
        check("reset/out_valid", 32'(Out_Valid), 32'd0);
        check("reset/result",    Result,         32'd0);
        check("reset/flags",     {29'd0, Overflow, Underflow, Zero}, 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during deep normalization: operation must vanish
        S_In = 1'b1; E_In = 8'h7F; M_In = 24'h000001; Carry_In = 1'b0; In_Valid = 1'b1;
        exp_q.push_back(vecs[2]);
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("rst_mid/busy", 32'(In_Ready), 32'd0);
        Reset = 1'b1; In_Valid = 1'b1;
        S_In = 1'b0; E_In = 8'h7F; M_In = 24'h800000; Carry_In = 1'b1;
        @(posedge Clk); #1;
        exp_q.delete();
        Reset = 1'b0; In_Valid = 1'b0;
        check("rst_mid/in_ready",  32'(In_Ready),  32'd1);
        check("rst_mid/out_valid", 32'(Out_Valid), 32'd0);
        check("rst_mid/result",    Result,         32'd0);
        check("rst_mid/flags",     {29'd0, Overflow, Underflow, Zero}, 32'd0);
        seen_valid = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clk); #1;
            if (Out_Valid) seen_valid++;
        end
        check("rst_mid/no_valid",   32'(seen_valid), 32'd0);
        check("rst_mid/still_idle", 32'(In_Ready),   32'd1);

        // Normal operation after the aborted one
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fp_normalize_pack
